// File: rtl/rf_exec_pkg.sv
// Shared types and instruction-field helpers for the register-file execution controller.
package rf_exec_pkg;

    localparam int RF_DATA_W = 4;
    localparam int RF_ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_MOV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Instruction layout is {op, rd, rs, ru} with ru in the low bits.
    function automatic int rs_lsb(input int aw);
        return aw;
    endfunction

    function automatic int rd_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

    function automatic logic op_sets_flags(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational ALU: result, zero and carry/borrow from op and two operands.
module rf_exec_alu
    import rf_exec_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  op_t               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] wide;

    // The extra top bit carries ADD carry-out or SUB borrow; zero for other ops.
    always_comb begin
        wide = '0;
        case (op_i)
            OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  wide = {1'b0, a_i & b_i};
            OP_OR:   wide = {1'b0, a_i | b_i};
            OP_XOR:  wide = {1'b0, a_i ^ b_i};
            OP_LDI:  wide = {1'b0, b_i};
            OP_MOV:  wide = {1'b0, a_i};
            default: wide = '0;
        endcase
        result_o = wide[DATA_W-1:0];
        z_o      = (wide[DATA_W-1:0] == '0);
        c_o      = wide[DATA_W];
    end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Four-cycle fetch/read/execute/write controller driving a 2R1W register file.
module rf_exec_ctrl
    import rf_exec_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3+3*ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0]     rs_addr,
    output logic [ADDR_W-1:0]     ru_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     ru_data,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [DATA_W-1:0]     w_data,
    output logic                  w_wr,
    output logic                  done,
    output logic                  flag_z,
    output logic                  flag_c
);

    localparam int INSTR_W = 3 + 3 * ADDR_W;
    localparam int RS_LSB  = rs_lsb(ADDR_W);
    localparam int RD_LSB  = rd_lsb(ADDR_W);
    localparam int OP_LSB  = op_lsb(ADDR_W);

    state_t              state_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic                ready_q;
    logic                w_wr_q;
    logic                done_q;
    logic                z_q;
    logic                c_q;

    op_t                 op;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_z;
    logic                alu_c;

    assign op  = op_t'(instr_q[OP_LSB +: 3]);
    assign imm = instr_q[DATA_W-1:0];

    rf_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    // Operand B carries the immediate for LDI so the ALU sees a uniform a/b pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ready_q <= 1'b1;
            w_wr_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        ready_q <= 1'b0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    a_q     <= rs_data;
                    b_q     <= (op == OP_LDI) ? imm : ru_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_res;
                    if (op_sets_flags(op)) begin
                        z_q <= alu_z;
                        c_q <= alu_c;
                    end
                    w_wr_q  <= (op != OP_NOP);
                    done_q  <= 1'b1;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    w_wr_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign rs_addr     = instr_q[RS_LSB +: ADDR_W];
    assign ru_addr     = instr_q[0 +: ADDR_W];
    assign w_addr      = instr_q[RD_LSB +: ADDR_W];
    assign w_data      = res_q;
    assign w_wr        = w_wr_q;
    assign done        = done_q;
    assign flag_z      = z_q;
    assign flag_c      = c_q;

endmodule
